// File: rtl/mix_columns_serial.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_serial
//  Purpose  : Iterative MixColumns engine for the Blink-128 datapath. Holds
//             one 128-bit state (32 nibble cells) and diffuses COLS_PER_CYCLE
//             column groups per clock, writing results back in place.
//             Valid/ready handshake on both the input and output side.
//  Revision : 1.0  initial release
// ============================================================================
module mix_columns_serial #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Cycles needed to sweep all eight column groups.
    localparam int NGROUPS = 8 / COLS_PER_CYCLE;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NGROUPS - 1);

    // Only divisors of eight give an exact sweep of the eight groups.
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
              COLS_PER_CYCLE == 4 || COLS_PER_CYCLE == 8)) begin : g_bad_cols
            $error("mix_columns_serial: COLS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [127:0]       st;
    logic [127:0]       st_next;
    logic [127:0]       mixed;

    // Upstream may load while idle, or while the finished result is being
    // taken in the same cycle (no bubble between back-to-back states).
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_data = st;

    // Diffuse the groups selected by the counter; other cells pass through.
    // Each output cell is the XOR of the whole group with its own value removed.
    always_comb begin
        mixed = st;
        for (int c = 0; c < COLS_PER_CYCLE; c++) begin : mix_loop
            int         grp;
            int         base;
            logic [3:0] n0;
            logic [3:0] n1;
            logic [3:0] n2;
            logic [3:0] n3;
            logic [3:0] sum;
            grp  = int'(cnt) * COLS_PER_CYCLE + c;
            base = 16 * (grp / 4) + (grp % 4);
            n0   = st[4*base      +: 4];
            n1   = st[4*(base+4)  +: 4];
            n2   = st[4*(base+8)  +: 4];
            n3   = st[4*(base+12) +: 4];
            sum  = n0 ^ n1 ^ n2 ^ n3;
            mixed[4*base      +: 4] = sum ^ n0;
            mixed[4*(base+4)  +: 4] = sum ^ n1;
            mixed[4*(base+8)  +: 4] = sum ^ n2;
            mixed[4*(base+12) +: 4] = sum ^ n3;
        end
    end

    // Next-state, counter and state-register update decisions.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        st_next    = st;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    st_next    = in_data;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                st_next = mixed;
                if (cnt == LAST_GROUP) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        st_next    = in_data;
                        cnt_next   = '0;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers and registered status outputs that track the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            st        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            st        <= st_next;
            out_valid <= (state_next == DONE);
            busy      <= (state_next == BUSY);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_columns_serial
//  Purpose  : Self-checking bench for mix_columns_serial, one instance per
//             legal COLS_PER_CYCLE (1, 2, 4, 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mix_columns_serial;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [4];
    logic         ordy [4];
    logic [127:0] id   [4];
    logic         ir   [4];
    logic         ov   [4];
    logic         bsy  [4];
    logic [127:0] od   [4];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used for latency measurement.
    always @(posedge clk) cyc++;

    mix_columns_serial #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0]));
    mix_columns_serial #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1]));
    mix_columns_serial #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bsy[2]));
    mix_columns_serial #(.COLS_PER_CYCLE(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .busy(bsy[3]));

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl [6];
    int   lat_of [4];

    // Reference: each cell becomes the XOR of the other three cells of its group.
    function automatic logic [127:0] mix_model(input logic [127:0] x);
        logic [127:0] y;
        logic [3:0]   acc;
        int           l;
        int           col;
        int           j;
        y = '0;
        for (int k = 0; k < 32; k++) begin
            l   = k / 16;
            col = k % 4;
            acc = 4'h0;
            for (int m = 0; m < 4; m++) begin
                j = 16 * l + col + 4 * m;
                if (j != k) acc = acc ^ x[4*j +: 4];
            end
            y[4*k +: 4] = acc;
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // Present data and hold until accepted; returns the cycle count after the accept edge.
    task automatic send(input int idx, input logic [127:0] data, output int acc_cyc);
        int n;
        iv[idx] = 1'b1;
        id[idx] = data;
        #1;
        n = 0;
        while (!ir[idx] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ir[idx]) begin
            chk($sformatf("send_timeout[%0d]", idx), 128'(ir[idx]), 128'(1));
            iv[idx] = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        iv[idx] = 1'b0;
        id[idx] = ~data;
    endtask

    // Wait (bounded) at negedges for out_valid.
    task automatic wait_out(input int idx);
        int n;
        n = 0;
        while (!ov[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ov[idx]) chk($sformatf("out_timeout[%0d]", idx), 128'(ov[idx]), 128'(1));
    endtask

    task automatic run_vec(input int idx, input logic [127:0] din, input logic [127:0] exp,
                           input string name);
        int acc;
        ordy[idx] = 1'b1;
        send(idx, din, acc);
        wait_out(idx);
        chk($sformatf("%s_data[%0d]", name, idx), od[idx], exp);
        chk($sformatf("%s_lat[%0d]", name, idx), 128'(cyc - acc), 128'(lat_of[idx]));
        @(negedge clk);
        chk($sformatf("%s_consumed[%0d]", name, idx), 128'(ov[idx]), 128'(0));
    endtask

    // Random valid/ready traffic checked through an expected-result queue.
    task automatic rnd_run(input int idx, input int nv);
        logic [127:0] q[$];
        logic [127:0] pd;
        logic         pending;
        int           sent;
        int           guard;
        pending = 1'b0;
        sent    = 0;
        guard   = 0;
        pd      = '0;
        while ((sent < nv || q.size() > 0) && guard < nv * 40) begin
            ordy[idx] = ($urandom_range(0, 3) != 0);
            if (!pending && sent < nv && $urandom_range(0, 2) != 0) begin
                pending = 1'b1;
                pd = {$urandom, $urandom, $urandom, $urandom};
            end
            iv[idx] = pending;
            id[idx] = pending ? pd : {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (ov[idx] && ordy[idx]) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL rnd_unexpected[%0d]: got output %h required none", idx, od[idx]);
                end else begin
                    chk($sformatf("rnd_data[%0d]", idx), od[idx], q.pop_front());
                end
            end
            if (pending && ir[idx]) begin
                q.push_back(mix_model(pd));
                pending = 1'b0;
                sent++;
            end
            @(negedge clk);
            guard++;
        end
        iv[idx]   = 1'b0;
        ordy[idx] = 1'b1;
        chk($sformatf("rnd_sent[%0d]", idx), 128'(sent), 128'(nv));
        chk($sformatf("rnd_drain[%0d]", idx), 128'(q.size()), 128'(0));
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] v;
        logic [127:0] held;
        logic [127:0] a;
        logic [127:0] b;
        int           acc;
        int           seen;

        tbl[0] = '{128'h1, 128'h0000000000000000_0001000100010000};
        tbl[1] = '{{128{1'b1}}, {128{1'b1}}};
        tbl[2] = '{128'h0, 128'h0};
        tbl[3] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 128'h0123456789ABCDEF_FEDCBA9876543210};
        tbl[4] = '{128'h0000000000000010_0000000000000000, 128'h0010001000100000_0000000000000000};
        tbl[5] = '{128'h0000000000000000_000000000005000A, 128'h0000000000000000_000F000F000A0005};
        lat_of = '{8, 4, 2, 1};

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; id[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(ov[0]), 128'(0));
        chk("rst_busy", 128'(bsy[0]), 128'(0));
        chk("rst_out_data", od[0], 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_in_ready[%0d]", i), 128'(ir[i]), 128'(1));

        // Table vectors on every width.
        for (int i = 0; i < 4; i++)
            for (int t = 0; t < 6; t++)
                run_vec(i, tbl[t].din, tbl[t].dout, $sformatf("tbl%0d", t));

        // Stall for five cycles with a rejected in_valid pulse, then involution.
        v = 128'h0123456789ABCDEF_FEDCBA9876543210 ^ {$urandom, $urandom, $urandom, $urandom};
        ordy[0] = 1'b0;
        send(0, v, acc);
        wait_out(0);
        held = od[0];
        chk("stall_data", held, mix_model(v));
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin iv[0] = 1'b1; id[0] = ~v; end
            if (s == 2) iv[0] = 1'b0;
            #1;
            chk("stall_in_ready", 128'(ir[0]), 128'(0));
            chk("stall_hold", od[0], held);
            chk("stall_valid", 128'(ov[0]), 128'(1));
            @(negedge clk);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("stall_released", 128'(ov[0]), 128'(0));
        chk("stall_pulse_ignored", 128'(bsy[0]), 128'(0));
        run_vec(0, held, v, "invol");

        // Consume and accept in the same DONE cycle.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        ordy[0] = 1'b0;
        send(0, a, acc);
        wait_out(0);
        chk("b2b_first", od[0], mix_model(a));
        iv[0] = 1'b1; id[0] = b; ordy[0] = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(ir[0]), 128'(1));
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        iv[0] = 1'b0; id[0] = ~b;
        chk("b2b_busy", 128'(bsy[0]), 128'(1));
        chk("b2b_valid_low", 128'(ov[0]), 128'(0));
        wait_out(0);
        chk("b2b_second", od[0], mix_model(b));
        chk("b2b_lat", 128'(cyc - acc), 128'(8));
        @(negedge clk);

        // Asynchronous reset in the middle of BUSY discards the state.
        send(0, {$urandom, $urandom, $urandom, $urandom}, acc);
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 128'(bsy[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 128'(ov[0]), 128'(0));
        chk("abort_busy", 128'(bsy[0]), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 128'(ir[0]), 128'(1));
        seen = 0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        chk("abort_no_output", 128'(seen), 128'(0));
        v = {$urandom, $urandom, $urandom, $urandom};
        run_vec(0, v, mix_model(v), "post_abort");

        // Random traffic.
        rnd_run(0, 1000);
        rnd_run(1, 100);
        rnd_run(2, 100);
        rnd_run(3, 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
